dca_neugemm_step_sequencer: RTL and testbench

//  Issues blocked-step instructions to the NeuGEMM compute array. Gates each step on per-channel load-LSU readiness,

---
 rtl/dca_neugemm_step_sequencer_pkg.sv | 26 ++
 rtl/dca_neugemm_step_sequencer_credit_counter.sv | 54 +++++
 rtl/dca_neugemm_step_sequencer.sv | 142 ++++++++++++++
 tb/tb_dca_neugemm_step_sequencer.sv | 594 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_neugemm_step_sequencer_pkg.sv
// Shared definitions for the NeuGEMM step sequencer: instruction field layout,
// decoded opcode view and FSM state encoding.
package dca_neugemm_step_sequencer_pkg;

    localparam int BW_OPCODE      = 8;
    localparam int OP_NO_CAL      = 0;
    localparam int OP_LOAD_ACC    = 1;
    localparam int OP_STORE_REQ   = 2;
    localparam int OP_LD_REQ_BASE = 3;
    localparam int MAX_LD_CH      = 4;
    localparam int SYNC_BIT       = BW_OPCODE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DRAIN = 2'd2
    } step_state_e;

    typedef struct packed {
        logic no_cal;
        logic load_acc;
        logic store_req;
        logic sync;
    } step_op_t;

endpackage

// File: rtl/dca_neugemm_step_sequencer_credit_counter.sv
// Outstanding-store credit counter: push adds a credit, ack returns one, an ack
// with nothing outstanding is held at zero and latched as a sticky underflow.
module dca_store_credit_counter #(
    parameter int DEPTH  = 3,
    parameter int BW_CNT = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstnn,
    input  logic              clear,
    input  logic              inc,
    input  logic              dec,
    output logic [BW_CNT-1:0] count,
    output logic              full,
    output logic              empty_next,
    output logic              underflow
);

    logic [BW_CNT-1:0] count_next;
    logic              underflow_hit;

    assign full       = (count == BW_CNT'(DEPTH));
    assign empty_next = (count_next == '0);

    always_comb begin
        count_next    = count;
        underflow_hit = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (inc && !dec) begin
            count_next = count + 1'b1;
        end else if (dec && !inc) begin
            if (count == '0) begin
                underflow_hit = 1'b1;
            end else begin
                count_next = count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            count <= count_next;
            if (clear) begin
                underflow <= 1'b0;
            end else if (underflow_hit) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dca_neugemm_step_sequencer.sv
// NeuGEMM step sequencer: gates each blocked step on load-LSU, accumulator and
// store-credit readiness, issues it to the array and retires it on completion.
module dca_neugemm_step_sequencer
    import dca_neugemm_step_sequencer_pkg::*;
#(
    parameter int NUM_LD_CH    = 2,
    parameter int STORE_CREDIT = 3,
    parameter int BW_INST      = 64,
    parameter int BW_STALL     = 32,
    parameter int BW_CREDIT    = $clog2(STORE_CREDIT + 1)
) (
    input  logic                 clk,
    input  logic                 rstnn,
    input  logic                 clear,
    input  logic                 enable,
    output logic                 busy,
    input  logic                 inst_valid,
    input  logic [BW_INST-1:0]   inst,
    output logic                 inst_ready,
    input  logic [NUM_LD_CH-1:0] ld_ready,
    output logic [NUM_LD_CH-1:0] ld_req,
    output logic [NUM_LD_CH-1:0] ld_pop,
    input  logic                 acc_ready,
    output logic                 acc_pop,
    output logic                 st_push,
    input  logic                 st_ack,
    input  logic                 array_ready,
    output logic                 array_issue,
    output logic [BW_INST-1:0]   array_inst,
    input  logic                 array_done,
    output logic [BW_CREDIT-1:0] credit_used,
    output logic                 err_underflow,
    output logic [BW_STALL-1:0]  stall_cycles
);

    step_state_e          state;
    step_state_e          state_next;
    step_op_t             op;
    logic [NUM_LD_CH-1:0] ld_mask;
    logic                 active;
    logic                 ld_ok;
    logic                 acc_ok;
    logic                 st_ok;
    logic                 credit_full;
    logic                 credit_empty_next;
    logic                 issue;
    logic                 retire;
    logic                 stall_hit;

    assign op.no_cal    = inst[OP_NO_CAL];
    assign op.load_acc  = inst[OP_LOAD_ACC];
    assign op.store_req = inst[OP_STORE_REQ];
    assign op.sync      = inst[SYNC_BIT];
    assign ld_mask      = inst[OP_LD_REQ_BASE +: NUM_LD_CH];

    // Outputs are forced low while reset is held or a soft clear is in progress.
    assign active = rstnn & ~clear;
    assign ld_ok  = &(ld_ready | ~ld_mask);
    assign acc_ok = ~op.load_acc | acc_ready;
    assign st_ok  = ~op.store_req | ~credit_full;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        retire     = 1'b0;
        stall_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && inst_valid) begin
                    if (op.no_cal) begin
                        retire = acc_ok & st_ok;
                    end else begin
                        issue = array_ready & ld_ok & acc_ok & st_ok;
                    end
                    stall_hit = ~(issue | retire);
                end
                if (issue) begin
                    state_next = ST_EXEC;
                end else if (retire) begin
                    state_next = op.sync ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (array_done) begin
                    retire     = 1'b1;
                    state_next = op.sync ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (credit_empty_next) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state <= ST_IDLE;
        end else if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            stall_cycles <= '0;
        end else if (clear) begin
            stall_cycles <= '0;
        end else if (stall_hit && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign array_issue = active & issue;
    assign ld_req      = (active & issue) ? ld_mask : '0;
    assign inst_ready  = active & retire;
    assign ld_pop      = (active & retire) ? ld_mask : '0;
    assign acc_pop     = active & retire & op.load_acc;
    assign st_push     = active & retire & op.store_req;
    assign busy        = active & (state != ST_IDLE);
    assign array_inst  = active ? inst : '0;

    dca_store_credit_counter #(
        .DEPTH  (STORE_CREDIT),
        .BW_CNT (BW_CREDIT)
    ) u_credit (
        .clk        (clk),
        .rstnn      (rstnn),
        .clear      (clear),
        .inc        (st_push),
        .dec        (st_ack),
        .count      (credit_used),
        .full       (credit_full),
        .empty_next (credit_empty_next),
        .underflow  (err_underflow)
    );

endmodule

// File: tb/tb_dca_neugemm_step_sequencer.sv
// Self-checking bench for the NeuGEMM step sequencer: directed scenarios with
// fixed expectations, then randomized traffic against a behavioural model.
module tb_dca_neugemm_step_sequencer;
    import dca_neugemm_step_sequencer_pkg::*;

    localparam int NUM_LD_CH    = 2;
    localparam int STORE_CREDIT = 3;
    localparam int BW_INST      = 64;
    localparam int BW_STALL     = 32;

    logic                 clk;
    logic                 rstnn;
    logic                 clear;
    logic                 enable;
    logic                 busy;
    logic                 inst_valid;
    logic [BW_INST-1:0]   inst;
    logic                 inst_ready;
    logic [NUM_LD_CH-1:0] ld_ready;
    logic [NUM_LD_CH-1:0] ld_req;
    logic [NUM_LD_CH-1:0] ld_pop;
    logic                 acc_ready;
    logic                 acc_pop;
    logic                 st_push;
    logic                 st_ack;
    logic                 array_ready;
    logic                 array_issue;
    logic [BW_INST-1:0]   array_inst;
    logic                 array_done;
    logic [1:0]           credit_used;
    logic                 err_underflow;
    logic [BW_STALL-1:0]  stall_cycles;

    int checks   = 0;
    int failures = 0;

    bit      m_exec;
    bit      m_drain;
    bit      m_err;
    int      m_credits;
    longint  m_stalls;

    dca_neugemm_step_sequencer #(
        .NUM_LD_CH    (NUM_LD_CH),
        .STORE_CREDIT (STORE_CREDIT),
        .BW_INST      (BW_INST),
        .BW_STALL     (BW_STALL)
    ) dut (
        .clk           (clk),
        .rstnn         (rstnn),
        .clear         (clear),
        .enable        (enable),
        .busy          (busy),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_ready    (inst_ready),
        .ld_ready      (ld_ready),
        .ld_req        (ld_req),
        .ld_pop        (ld_pop),
        .acc_ready     (acc_ready),
        .acc_pop       (acc_pop),
        .st_push       (st_push),
        .st_ack        (st_ack),
        .array_ready   (array_ready),
        .array_issue   (array_issue),
        .array_inst    (array_inst),
        .array_done    (array_done),
        .credit_used   (credit_used),
        .err_underflow (err_underflow),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of run, expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [BW_INST-1:0] make_inst(input bit no_cal, input bit load_acc,
                                                     input bit store_req, input logic [1:0] ldm,
                                                     input bit sync);
        logic [BW_INST-1:0] v;
        v = {$urandom, $urandom};
        v[OP_NO_CAL]          = no_cal;
        v[OP_LOAD_ACC]        = load_acc;
        v[OP_STORE_REQ]       = store_req;
        v[OP_LD_REQ_BASE +: 2] = ldm;
        v[SYNC_BIT]           = sync;
        return v;
    endfunction

    task automatic idle_inputs();
        clear       = 1'b0;
        enable      = 1'b1;
        inst_valid  = 1'b0;
        ld_ready    = 2'b11;
        acc_ready   = 1'b1;
        st_ack      = 1'b0;
        array_ready = 1'b1;
        array_done  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        inst_valid = 1'b1;
        inst = make_inst(1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        rstnn = 1'b1;
        #1 rstnn = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (array_issue !== 1'b0 || ld_req !== 2'b00 || inst_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_comb: got issue=%b req=%b ready=%b busy=%b, expected all 0",
                     array_issue, ld_req, inst_ready, busy);
        end
        checks++;
        if (credit_used !== 2'd0 || err_underflow !== 1'b0 || stall_cycles !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_regs: got credit=%0d err=%b stall=%0d, expected 0 0 0",
                     credit_used, err_underflow, stall_cycles);
        end
        checks++;
        if (array_inst !== '0) begin
            failures++;
            $display("[TB] FAIL reset_inst: got %h expected 0", array_inst);
        end
        @(negedge clk);
        rstnn = 1'b1;
        inst_valid = 1'b0;
    endtask

    task automatic test_compute();
        logic [BW_INST-1:0] want;
        @(negedge clk);
        idle_inputs();
        inst_valid = 1'b1;
        want = make_inst(1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        inst = want;
        #1;
        checks++;
        if (array_issue !== 1'b1 || ld_req !== 2'b11 || inst_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL compute_issue: got issue=%b req=%b ready=%b, expected 1 11 0",
                     array_issue, ld_req, inst_ready);
        end
        checks++;
        if (array_inst !== want) begin
            failures++;
            $display("[TB] FAIL compute_passthru: got %h expected %h", array_inst, want);
        end
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (busy !== 1'b1 || array_issue !== 1'b0 || inst_ready !== 1'b0 || ld_req !== 2'b00) begin
                failures++;
                $display("[TB] FAIL compute_wait: got busy=%b issue=%b ready=%b req=%b, expected 1 0 0 00",
                         busy, array_issue, inst_ready, ld_req);
            end
        end
        @(negedge clk);
        array_done = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b1 || ld_pop !== 2'b11 || st_push !== 1'b1 || acc_pop !== 1'b0 || array_issue !== 1'b0) begin
            failures++;
            $display("[TB] FAIL compute_retire: got ready=%b pop=%b push=%b acc=%b issue=%b, expected 1 11 1 0 0",
                     inst_ready, ld_pop, st_push, acc_pop, array_issue);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (credit_used !== 2'd1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL compute_credit: got credit=%0d busy=%b, expected 1 0", credit_used, busy);
        end
    endtask

    task automatic test_credit_stall();
        @(negedge clk);
        idle_inputs();
        st_ack = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            idle_inputs();
            inst_valid = 1'b1;
            inst = make_inst(1'b0, 1'b0, 1'b1, 2'($urandom), 1'b0);
            #1;
            checks++;
            if (array_issue !== 1'b1) begin
                failures++;
                $display("[TB] FAIL store_issue%0d: got issue=%b expected 1", s, array_issue);
            end
            @(negedge clk);
            array_done = 1'b1;
            #1;
            checks++;
            if (st_push !== 1'b1 || inst_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL store_retire%0d: got push=%b ready=%b expected 1 1", s, st_push, inst_ready);
            end
        end
        @(negedge clk);
        idle_inputs();
        inst_valid = 1'b1;
        inst = make_inst(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if (array_issue !== 1'b0 || stall_cycles !== 32'(k) || credit_used !== 2'd3) begin
                failures++;
                $display("[TB] FAIL full_stall%0d: got issue=%b stall=%0d credit=%0d, expected 0 %0d 3",
                         k, array_issue, stall_cycles, credit_used, k);
            end
        end
        @(negedge clk);
        st_ack = 1'b1;
        #1;
        checks++;
        if (array_issue !== 1'b0 || stall_cycles !== 32'd3) begin
            failures++;
            $display("[TB] FAIL ack_cycle: got issue=%b stall=%0d, expected 0 3", array_issue, stall_cycles);
        end
        @(negedge clk);
        st_ack = 1'b0;
        #1;
        checks++;
        if (array_issue !== 1'b1 || stall_cycles !== 32'd4 || credit_used !== 2'd2) begin
            failures++;
            $display("[TB] FAIL issue_after_ack: got issue=%b stall=%0d credit=%0d, expected 1 4 2",
                     array_issue, stall_cycles, credit_used);
        end
        @(negedge clk);
        array_done = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fourth_retire: got ready=%b expected 1", inst_ready);
        end
        repeat (3) begin
            @(negedge clk);
            idle_inputs();
            st_ack = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (credit_used !== 2'd0) begin
            failures++;
            $display("[TB] FAIL credit_return: got credit=%0d expected 0", credit_used);
        end
    endtask

    task automatic test_sync_drain();
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            idle_inputs();
            inst_valid = 1'b1;
            inst = make_inst(1'b0, 1'b0, 1'b1, 2'($urandom), 1'b0);
            @(negedge clk);
            array_done = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        inst_valid = 1'b1;
        inst = make_inst(1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
        #1;
        checks++;
        if (array_issue !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sync_issue: got issue=%b expected 1", array_issue);
        end
        @(negedge clk);
        array_done = 1'b1;
        st_ack = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b1 || st_push !== 1'b1 || ld_pop !== 2'b10) begin
            failures++;
            $display("[TB] FAIL sync_retire: got ready=%b push=%b pop=%b, expected 1 1 10",
                     inst_ready, st_push, ld_pop);
        end
        @(negedge clk);
        idle_inputs();
        inst_valid = 1'b1;
        inst = make_inst(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b1 || credit_used !== 2'd2 || array_issue !== 1'b0) begin
            failures++;
            $display("[TB] FAIL push_ack_hold: got busy=%b credit=%0d issue=%b, expected 1 2 0",
                     busy, credit_used, array_issue);
        end
        for (int d = 2; d <= 5; d++) begin
            @(negedge clk);
            st_ack = (d == 2 || d == 5);
            #1;
            checks++;
            if (busy !== 1'b1 || array_issue !== 1'b0 || credit_used !== ((d <= 2) ? 2'd2 : 2'd1)) begin
                failures++;
                $display("[TB] FAIL drain_t%0d: got busy=%b issue=%b credit=%0d, expected 1 0 %0d",
                         d, busy, array_issue, credit_used, (d <= 2) ? 2 : 1);
            end
        end
        @(negedge clk);
        st_ack = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || credit_used !== 2'd0 || array_issue !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drain_exit: got busy=%b credit=%0d issue=%b, expected 0 0 1",
                     busy, credit_used, array_issue);
        end
        @(negedge clk);
        array_done = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b1 || ld_pop !== 2'b01 || st_push !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_drain_retire: got ready=%b pop=%b push=%b, expected 1 01 0",
                     inst_ready, ld_pop, st_push);
        end
    endtask

    task automatic test_nocal();
        @(negedge clk);
        idle_inputs();
        clear = 1'b1;
        @(negedge clk);
        idle_inputs();
        inst_valid = 1'b1;
        inst = make_inst(1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        acc_ready = 1'b0;
        ld_ready = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if (inst_ready !== 1'b0 || array_issue !== 1'b0 || acc_pop !== 1'b0) begin
                failures++;
                $display("[TB] FAIL nocal_wait%0d: got ready=%b issue=%b acc=%b, expected 0 0 0",
                         k, inst_ready, array_issue, acc_pop);
            end
        end
        @(negedge clk);
        acc_ready = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b1 || acc_pop !== 1'b1 || array_issue !== 1'b0 || ld_req !== 2'b00 || ld_pop !== 2'b10) begin
            failures++;
            $display("[TB] FAIL nocal_retire: got ready=%b acc=%b issue=%b req=%b pop=%b, expected 1 1 0 00 10",
                     inst_ready, acc_pop, array_issue, ld_req, ld_pop);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (stall_cycles !== 32'd4 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nocal_stall: got stall=%0d busy=%b, expected 4 0", stall_cycles, busy);
        end
    endtask

    task automatic test_underflow_clear();
        @(negedge clk);
        idle_inputs();
        st_ack = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (err_underflow !== 1'b1 || credit_used !== 2'd0) begin
            failures++;
            $display("[TB] FAIL underflow: got err=%b credit=%0d, expected 1 0", err_underflow, credit_used);
        end
        @(negedge clk);
        inst_valid = 1'b1;
        inst = make_inst(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        acc_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        acc_ready = 1'b1;
        #1;
        checks++;
        if (array_issue !== 1'b0 || inst_ready !== 1'b0 || stall_cycles !== 32'd6) begin
            failures++;
            $display("[TB] FAIL clear_cycle: got issue=%b ready=%b stall=%0d, expected 0 0 6",
                     array_issue, inst_ready, stall_cycles);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (err_underflow !== 1'b0 || stall_cycles !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_clear: got err=%b stall=%0d busy=%b, expected 0 0 0",
                     err_underflow, stall_cycles, busy);
        end
        @(negedge clk);
        inst_valid = 1'b1;
        inst = make_inst(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        @(negedge clk);
        array_done = 1'b1;
        clear = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b0 || busy !== 1'b0 || ld_pop !== 2'b00) begin
            failures++;
            $display("[TB] FAIL clear_exec: got ready=%b busy=%b pop=%b, expected 0 0 00", inst_ready, busy, ld_pop);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (busy !== 1'b0 || inst_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_exec_after: got busy=%b ready=%b, expected 0 0", busy, inst_ready);
        end
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        idle_inputs();
        inst_valid = 1'b1;
        inst = make_inst(1'b0, 1'b1, 1'b1, 2'b11, 1'b0);
        #1;
        checks++;
        if (array_issue !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_issue: got issue=%b expected 1", array_issue);
        end
        @(negedge clk);
        array_done = 1'b1;
        rstnn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || inst_ready !== 1'b0 || ld_pop !== 2'b00 || acc_pop !== 1'b0 ||
            st_push !== 1'b0 || array_issue !== 1'b0 || array_inst !== '0) begin
            failures++;
            $display("[TB] FAIL rst_mid_exec: got busy=%b ready=%b pop=%b acc=%b push=%b issue=%b, expected all 0",
                     busy, inst_ready, ld_pop, acc_pop, st_push, array_issue);
        end
        @(negedge clk);
        rstnn = 1'b1;
        inst_valid = 1'b0;
        array_done = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b0 || busy !== 1'b0 || credit_used !== 2'd0) begin
            failures++;
            $display("[TB] FAIL done_in_idle: got ready=%b busy=%b credit=%0d, expected 0 0 0",
                     inst_ready, busy, credit_used);
        end
        @(negedge clk);
        idle_inputs();
        enable = 1'b0;
        inst_valid = 1'b1;
        inst = make_inst(1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        #1;
        checks++;
        if (array_issue !== 1'b0) begin
            failures++;
            $display("[TB] FAIL enable_block: got issue=%b expected 0", array_issue);
        end
        @(negedge clk);
        enable = 1'b1;
        #1;
        checks++;
        if (array_issue !== 1'b1) begin
            failures++;
            $display("[TB] FAIL enable_issue: got issue=%b expected 1", array_issue);
        end
        @(negedge clk);
        enable = 1'b0;
        array_done = 1'b1;
        #1;
        checks++;
        if (inst_ready !== 1'b1 || ld_pop !== 2'b11 || stall_cycles !== 32'd0) begin
            failures++;
            $display("[TB] FAIL exec_ignores_enable: got ready=%b pop=%b stall=%0d, expected 1 11 0",
                     inst_ready, ld_pop, stall_cycles);
        end
    endtask

    task automatic test_random();
        logic [BW_INST-1:0] cur_inst;
        logic [1:0]         ldm;
        logic [8:0]         got_v;
        logic [8:0]         exp_v;
        bit                 f_nocal, f_acc, f_store, f_sync;
        bit                 e_issue, e_retire, e_stall, e_push, e_busy;
        int                 cn;
        @(negedge clk);
        idle_inputs();
        clear = 1'b1;
        @(posedge clk);
        m_exec = 1'b0; m_drain = 1'b0; m_err = 1'b0; m_credits = 0; m_stalls = 0;
        cur_inst = {$urandom, $urandom};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            clear       = ($urandom_range(99) == 0);
            enable      = ($urandom_range(9) != 0);
            inst_valid  = m_exec ? 1'b1 : ($urandom_range(3) != 0);
            ld_ready    = 2'($urandom);
            acc_ready   = ($urandom_range(2) != 0);
            array_ready = ($urandom_range(3) != 0);
            array_done  = ($urandom_range(2) == 0);
            inst        = cur_inst;
            f_nocal = cur_inst[OP_NO_CAL];
            f_acc   = cur_inst[OP_LOAD_ACC];
            f_store = cur_inst[OP_STORE_REQ];
            f_sync  = cur_inst[SYNC_BIT];
            ldm     = cur_inst[OP_LD_REQ_BASE +: 2];
            e_issue = 1'b0; e_retire = 1'b0; e_stall = 1'b0;
            if (!clear) begin
                if (m_exec) begin
                    e_retire = array_done;
                end else if (!m_drain && enable && inst_valid) begin
                    if (f_nocal) begin
                        e_retire = (!f_acc || acc_ready) && (!f_store || m_credits < STORE_CREDIT);
                    end else begin
                        e_issue = array_ready && ((ld_ready & ldm) == ldm) && (!f_acc || acc_ready)
                                  && (!f_store || m_credits < STORE_CREDIT);
                    end
                    e_stall = !(e_issue || e_retire);
                end
            end
            e_push = e_retire && f_store;
            e_busy = !clear && (m_exec || m_drain);
            if (m_credits == 0) st_ack = e_push ? 1'b0 : ($urandom_range(19) == 0);
            else st_ack = ($urandom_range(2) == 0);
            #1;
            got_v = {array_issue, ld_req, inst_ready, ld_pop, acc_pop, st_push, busy};
            exp_v = {e_issue, e_issue ? ldm : 2'b00, e_retire, e_retire ? ldm : 2'b00,
                     e_retire && f_acc, e_push, e_busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL rand_strobes cyc%0d: got %b expected %b (issue,req,ready,pop,acc,push,busy)",
                         cyc, got_v, exp_v);
            end
            checks++;
            if (array_inst !== (clear ? '0 : cur_inst)) begin
                failures++;
                $display("[TB] FAIL rand_inst cyc%0d: got %h expected %h", cyc, array_inst, clear ? '0 : cur_inst);
            end
            checks++;
            if (credit_used !== 2'(m_credits) || err_underflow !== m_err || stall_cycles !== 32'(m_stalls)) begin
                failures++;
                $display("[TB] FAIL rand_regs cyc%0d: got credit=%0d err=%b stall=%0d expected %0d %b %0d",
                         cyc, credit_used, err_underflow, stall_cycles, m_credits, m_err, m_stalls);
            end
            @(posedge clk);
            if (clear) begin
                m_exec = 1'b0; m_drain = 1'b0; m_err = 1'b0; m_credits = 0; m_stalls = 0;
            end else begin
                cn = m_credits;
                if (e_push && !st_ack) cn++;
                else if (st_ack && !e_push) begin
                    if (cn == 0) m_err = 1'b1;
                    else cn--;
                end
                if (m_drain) m_drain = (cn != 0);
                else if (e_retire) m_drain = f_sync;
                if (e_retire) m_exec = 1'b0;
                if (e_issue) m_exec = 1'b1;
                m_credits = cn;
                if (e_stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            end
            if (e_retire) cur_inst = {$urandom, $urandom};
        end
    endtask

    initial begin
        test_reset();
        test_compute();
        test_credit_stall();
        test_sync_drain();
        test_nocal();
        test_underflow_clear();
        test_reset_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
